// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-ported memory between instruction fetch
// (IF) and load/store (LS), with at most one transaction outstanding.
// By default LS has strict priority over IF.
// Optional macro ARB_FAIRNESS_EN adds a starvation counter. After STARVE_LIMIT
// consecutive LS grants while IF waits, the counter forces one IF grant.
module imem_dmem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                fetch_stall,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } state_t;

    state_t state;
    logic   ls_load_q;   // outstanding LS transaction is a load
    logic   issue;
    logic   resp;
    logic   accept;
    logic   ls_sel;
    logic   force_if;

`ifdef ARB_FAIRNESS_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign force_if = if_req && (starve_cnt == LIMIT);

    // Count consecutive LS grants that made a waiting IF wait longer
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (ls_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign force_if   = 1'b0;
    assign unused_cfg = (STARVE_LIMIT == 0);
`endif

    // Arbitration, memory request mux and response routing
    always_comb begin
        issue       = 1'b0;
        resp        = 1'b0;
        ls_sel      = 1'b0;
        mem_req     = 1'b0;
        accept      = 1'b0;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        fetch_stall = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        ls_rvalid   = 1'b0;
        ls_rdata    = '0;

        // A new transaction may start when idle or on the response cycle
        issue   = !reset && ((state == IDLE) || mem_rvalid);
        resp    = !reset && (state != IDLE) && mem_rvalid;
        ls_sel  = ls_req && !force_if;
        mem_req = issue && (if_req || ls_req);
        accept  = mem_req && mem_ready;
        ls_gnt  = accept && ls_sel;
        if_gnt  = accept && !ls_sel;

        fetch_stall = if_req && !if_gnt;

        if (mem_req) begin
            if (ls_sel) begin
                mem_we    = ls_we;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
                mem_be    = ls_we ? ls_be : {BE_W{1'b1}};
            end else begin
                mem_addr  = if_addr;
                mem_be    = {BE_W{1'b1}};
            end
        end

        if_rvalid = resp && (state == WAIT_IF);
        ls_rvalid = resp && (state == WAIT_LS);
        if (if_rvalid) begin
            if_rdata = mem_rdata;
        end
        if (ls_rvalid && ls_load_q) begin
            ls_rdata = mem_rdata;
        end
    end

    // Outstanding-transaction owner tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ls_load_q <= 1'b0;
        end else if (accept) begin
            state     <= ls_sel ? WAIT_LS : WAIT_IF;
            ls_load_q <= ls_sel && !ls_we;
        end else if (resp) begin
            state     <= IDLE;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed testbench for imem_dmem_arbiter.
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
module tb_imem_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        fetch_stall;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .fetch_stall(fetch_stall),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // control bundle: {if_gnt, ls_gnt, fetch_stall, mem_req, if_rvalid, ls_rvalid}
    function automatic logic [5:0] ctl();
        return {if_gnt, ls_gnt, fetch_stall, mem_req, if_rvalid, ls_rvalid};
    endfunction

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; idle_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clock); #1;
        checks++;
        if ({ctl(), if_rdata, ls_rdata, mem_addr} !== {6'b000000, 96'h0}) begin
            fails++; $display("FAIL reset_outputs: got ctl=%b if_rdata=%h ls_rdata=%h mem_addr=%h, want all 0",
                              ctl(), if_rdata, ls_rdata, mem_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (ctl() !== 6'b000000) begin
            fails++; $display("FAIL idle_stale_rvalid: ctl=%b want 000000", ctl());
        end
    endtask

    task automatic test_if_fetch();
        @(negedge clock);
        idle_inputs(); if_req = 1'b1; if_addr = 32'h0100_0000;
        #1;
        checks++;
        if ({ctl(), mem_addr, mem_we, mem_be} !== {6'b100100, 32'h0100_0000, 1'b0, 4'hF}) begin
            fails++; $display("FAIL if_grant: ctl=%b addr=%h we=%b be=%h want 100100/01000000/0/f",
                              ctl(), mem_addr, mem_we, mem_be);
        end
        @(negedge clock);
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        checks++;
        if ({ctl(), if_rdata} !== {6'b000010, 32'h0000_0013}) begin
            fails++; $display("FAIL if_response: ctl=%b rdata=%h want 000010/00000013", ctl(), if_rdata);
        end
        @(negedge clock);
        mem_rdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (ctl() !== 6'b000000) begin
            fails++; $display("FAIL if_back_to_idle: ctl=%b want 000000", ctl());
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_priority();
        @(negedge clock);
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h0100_0004;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_2000; ls_be = 4'h1;
        #1;
        checks++;
        if ({ctl(), mem_addr, mem_be} !== {6'b011100, 32'h0000_2000, 4'hF}) begin
            fails++; $display("FAIL prio_ls_first: ctl=%b addr=%h be=%h want 011100/00002000/f",
                              ctl(), mem_addr, mem_be);
        end
        @(negedge clock);
        ls_req = 1'b0;
        #1;
        checks++;
        if (ctl() !== 6'b001000) begin
            fails++; $display("FAIL prio_stall_wait_ls: ctl=%b want 001000", ctl());
        end
        @(negedge clock);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        checks++;
        if ({ctl(), ls_rdata, mem_addr} !== {6'b100101, 32'hCAFE_0001, 32'h0100_0004}) begin
            fails++; $display("FAIL prio_ls_resp_if_grant: ctl=%b ls_rdata=%h addr=%h want 100101/cafe0001/01000004",
                              ctl(), ls_rdata, mem_addr);
        end
        @(negedge clock);
        if_req = 1'b0; mem_rdata = 32'h0000_0055;
        #1;
        checks++;
        if ({ctl(), if_rdata, ls_rdata} !== {6'b000010, 32'h0000_0055, 32'h0}) begin
            fails++; $display("FAIL prio_if_resp: ctl=%b if_rdata=%h ls_rdata=%h want 000010/00000055/0",
                              ctl(), if_rdata, ls_rdata);
        end
        @(negedge clock);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_store();
        @(negedge clock);
        idle_inputs();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_3000; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
        #1;
        checks++;
        if ({ctl(), mem_we, mem_be, mem_wdata, mem_addr} !== {6'b010100, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0000_3000}) begin
            fails++; $display("FAIL store_issue: ctl=%b we=%b be=%b wdata=%h addr=%h want 010100/1/0011/deadbeef/00003000",
                              ctl(), mem_we, mem_be, mem_wdata, mem_addr);
        end
        @(negedge clock);
        ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({ctl(), ls_rdata} !== {6'b000001, 32'h0}) begin
            fails++; $display("FAIL store_ack: ctl=%b ls_rdata=%h want 000001/00000000", ctl(), ls_rdata);
        end
        @(negedge clock);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_not_ready();
        @(negedge clock);
        idle_inputs(); mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h0100_0008;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({ctl(), mem_addr} !== {6'b001100, 32'h0100_0008}) begin
                fails++; $display("FAIL not_ready_hold%0d: ctl=%b addr=%h want 001100/01000008", i, ctl(), mem_addr);
            end
            @(negedge clock);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl() !== 6'b100100) begin
            fails++; $display("FAIL not_ready_grant: ctl=%b want 100100", ctl());
        end
        @(negedge clock);
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        #1;
        checks++;
        if ({ctl(), if_rdata} !== {6'b000010, 32'h0000_0077}) begin
            fails++; $display("FAIL not_ready_resp: ctl=%b rdata=%h want 000010/00000077", ctl(), if_rdata);
        end
        @(negedge clock);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        idle_inputs(); ls_req = 1'b1; ls_addr = 32'h0000_4000;
        #1;
        checks++;
        if (ctl() !== 6'b010100) begin
            fails++; $display("FAIL mid_ls_grant: ctl=%b want 010100", ctl());
        end
        @(negedge clock);
        ls_req = 1'b0; reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if ({ctl(), ls_rdata} !== {6'b000000, 32'h0}) begin
            fails++; $display("FAIL mid_during_reset: ctl=%b ls_rdata=%h want 000000/0", ctl(), ls_rdata);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({ctl(), ls_rdata, if_rdata} !== {6'b000000, 64'h0}) begin
            fails++; $display("FAIL mid_stale_dropped: ctl=%b ls_rdata=%h if_rdata=%h want 000000/0/0",
                              ctl(), ls_rdata, if_rdata);
        end
        @(negedge clock);
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h0100_000C;
        #1;
        checks++;
        if (ctl() !== 6'b100100) begin
            fails++; $display("FAIL mid_idle_after_reset: ctl=%b want 100100", ctl());
        end
        @(negedge clock);
        if_req = 1'b0; mem_rvalid = 1'b1;
        @(negedge clock);
        mem_rvalid = 1'b0;
    endtask

    // Both sides request continuously against a 1-cycle memory
    task automatic test_back_to_back();
        logic exp_if;
        @(negedge clock);
        reset = 1'b1; idle_inputs();
        @(negedge clock);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h0100_0010;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_5000;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid = (i > 0);
`ifdef ARB_FAIRNESS_EN
            exp_if = ((i % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            #1;
            checks++;
            if ({if_gnt, ls_gnt, fetch_stall} !== {exp_if, !exp_if, !exp_if}) begin
                fails++; $display("FAIL b2b_grant%0d: if_gnt=%b ls_gnt=%b stall=%b want %b/%b/%b",
                                  i, if_gnt, ls_gnt, fetch_stall, exp_if, !exp_if, !exp_if);
            end
            @(negedge clock);
        end
        idle_inputs(); mem_rvalid = 1'b1;
        @(negedge clock);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_if_fetch();
        test_priority();
        test_store();
        test_not_ready();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and load/store (LS).
- Sits between the fetch stage and the memory. Drives the fetch stall so the PC holds while IF is not granted.
- At most one transaction outstanding. In-order responses. Routes each response to the requester that issued it.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits; byte enables are DATA_W/8
- STARVE_LIMIT, 4, max consecutive LS grants while IF waits (used only with fairness feature)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch requests a read at if_addr
- if_addr  in  ADDR_W  fetch address (current PC)
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  if_rdata valid (one cycle)
- if_rdata  out  DATA_W  fetched instruction word
- fetch_stall  out  1  equals if_req && !if_gnt; drives the fetch stall_PC input
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_be  in  DATA_W/8  store byte enables
- ls_gnt  out  1  LS request accepted this cycle
- ls_rvalid  out  1  load data / store ack valid (one cycle)
- ls_rdata  out  DATA_W  load data; 0 for stores
- mem_req  out  1  request to memory
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  byte enables; all ones for IF reads and LS loads
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  response or write ack, ≥1 cycle after acceptance
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: state IDLE.
  - All grant, rvalid and mem_req outputs 0. Data outputs 0.
  - Starvation counter 0. Owner flag cleared.
- States:
  - IDLE: no transaction outstanding.
  - WAIT_IF: an IF transaction is outstanding.
  - WAIT_LS: an LS transaction is outstanding.
- Issue condition (combinational):
  - Issue when the state is IDLE, or when it is WAIT_* with mem_rvalid=1. The second case allows back-to-back issue on the response cycle.
  - Winner is chosen among if_req and ls_req.
  - mem_req = issue && (if_req || ls_req). Mux the winner's fields onto the mem_* outputs.
- Acceptance and grant:
  - Acceptance = mem_req && mem_ready.
  - On acceptance, assert the winner's gnt in the same cycle and go to WAIT_IF or WAIT_LS.
  - If mem_ready=0, there is no grant. Requesters hold their request. Arbitration is re-evaluated each cycle, so the winner may change.
- Default arbitration: LS has strict priority over IF. Simultaneous requests grant LS.
- Response:
  - In WAIT_IF, mem_rvalid drives if_rvalid=1 and if_rdata=mem_rdata in the same cycle (combinational, zero added latency).
  - In WAIT_LS, mem_rvalid drives ls_rvalid=1. ls_rdata=mem_rdata for loads (registered ls_we=0), 0 for stores.
  - On the response cycle, go to IDLE unless a new request is accepted in that same cycle.
- Minimum latency: grant at cycle N, rvalid at N+1 earliest when mem_rvalid returns after one cycle. Back-to-back throughput is one transaction per memory round trip.
- Error case: mem_rvalid in IDLE is ignored (no rvalid to either side). This covers a stale response after reset.
- Reset mid-transaction: go to IDLE next cycle, drop the outstanding response, deassert all outputs.
- fetch_stall: purely combinational. High whenever IF is requesting but not granted, including while an LS transaction is outstanding.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - Counter increments on each LS grant while if_req=1. It clears on an IF grant or when if_req=0.
  - When counter == STARVE_LIMIT, the next arbitration with if_req=1 grants IF even if ls_req=1.
  - Counter width is clog2(STARVE_LIMIT+1). It saturates at STARVE_LIMIT.
- Not defined: strict LS priority, no counter logic present.

Test Plan:
- Reset, then if_req=1 at if_addr=0x01000000 with mem_ready=1 and 1-cycle memory → if_gnt same cycle; if_rvalid next cycle with the memory word; fetch_stall=0.
- if_req and ls_req (load, 0x00002000) asserted together → ls_gnt first, fetch_stall=1 until the LS response. IF is granted on the LS rvalid cycle.
- Store ls_we=1, ls_be=4'b0011, ls_wdata=0xDEADBEEF → mem_we=1 with mem_be=0011; ls_rvalid on ack with ls_rdata=0.
- mem_ready=0 for 3 cycles with if_req held → no gnt, mem_req held, fetch_stall=1. Grant on the first ready cycle.
- Reset asserted while in WAIT_LS, mem_rvalid arrives after reset → no ls_rvalid or if_rvalid; state IDLE.
- ARB_FAIRNESS_EN, STARVE_LIMIT=4, both requesting continuously → 4 LS grants, then 1 IF grant, repeating.
